// File: rtl/lcd_clock_writer_pkg.sv
// Shared LCD command bytes, ASCII constants, state encodings and frame helpers
// for the HD44780 clock display writer.
package lcd_clock_writer_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_DDRAM    = 8'h80;
  localparam logic [7:0] CH_COLON     = 8'h3A;
  localparam logic [7:0] CH_SPACE     = 8'h20;

  localparam logic [3:0] N_INIT  = 4'd4;
  localparam logic [3:0] N_CHARS = 4'd11;

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_CLR_WAIT, S_ADDR, S_CHAR, S_GAP
  } state_t;

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_STROBE, P_HOLD} phase_t;

  typedef struct packed {
    logic [7:0] hour_10;
    logic [7:0] hour_1;
    logic [7:0] min_10;
    logic [7:0] min_1;
    logic [7:0] sec_10;
    logic [7:0] sec_1;
    logic [7:0] cnt_10;
    logic [7:0] cnt_1;
  } frame_t;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    return LCD_FUNC_SET;
      4'd1:    return LCD_DISP_ON;
      4'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Anything that is not an ASCII digit (including the upstream 8'h00) shows as blank.
  function automatic logic [7:0] sanitise(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? c : CH_SPACE;
  endfunction

  function automatic logic [7:0] frame_char(input frame_t f, input logic [3:0] idx);
    case (idx)
      4'd0:                 return sanitise(f.hour_10);
      4'd1:                 return sanitise(f.hour_1);
      4'd3:                 return sanitise(f.min_10);
      4'd4:                 return sanitise(f.min_1);
      4'd6:                 return sanitise(f.sec_10);
      4'd7:                 return sanitise(f.sec_1);
      4'd9:                 return sanitise(f.cnt_10);
      4'd10:                return sanitise(f.cnt_1);
      4'd2, 4'd5, 4'd8:     return CH_COLON;
      default:              return CH_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_strobe.sv
// Three-phase LCD bus write: SETUP (bus driven, e=0), STROBE (e=1), HOLD (e=0).
// done is high during HOLD so the sequencer can start the next write back-to-back.
module lcd_strobe
  import lcd_clock_writer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  phase_t phase, phase_next;

  always_comb begin
    phase_next = phase;
    case (phase)
      P_IDLE:   if (start) phase_next = P_SETUP;
      P_SETUP:  phase_next = P_STROBE;
      P_STROBE: phase_next = P_HOLD;
      P_HOLD:   phase_next = start ? P_SETUP : P_IDLE;
      default:  phase_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase    <= P_IDLE;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase <= phase_next;
      lcd_e <= (phase_next == P_STROBE);
      if (start && (phase == P_IDLE || phase == P_HOLD)) begin
        lcd_rs   <= cmd_rs;
        lcd_data <= cmd_data;
      end
    end
  end

  assign done = (phase == P_HOLD);

endmodule

// File: rtl/lcd_clock_writer.sv
// Initialises an HD44780 LCD then endlessly rewrites one line as HH:MM:SS:CC
// from a snapshot of the digit inputs taken at the start of each frame.
module lcd_clock_writer
  import lcd_clock_writer_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 40,
  parameter int unsigned CLEAR_WAIT     = 2,
  parameter int unsigned REFRESH_GAP    = 4,
  parameter logic [6:0]  DDRAM_ADDR     = 7'h00
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] hour_10,
  input  logic [7:0] hour_1,
  input  logic [7:0] min_10,
  input  logic [7:0] min_1,
  input  logic [7:0] sec_10,
  input  logic [7:0] sec_1,
  input  logic [7:0] cnt_10,
  input  logic [7:0] cnt_1,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       ready
);

  localparam int unsigned W_MAX01 = (POWERUP_CYCLES > CLEAR_WAIT) ? POWERUP_CYCLES : CLEAR_WAIT;
  localparam int unsigned W_MAX   = (W_MAX01 > REFRESH_GAP) ? W_MAX01 : REFRESH_GAP;
  localparam int          CNT_W   = $clog2(W_MAX) + 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       idx, idx_next;
  frame_t           snap;
  logic             issue, issue_rs, addr_go, done;
  logic [7:0]       issue_data;

  // A wait state's entry edge is its first idle cycle, so entry loads cnt with 1;
  // a zero wait skips the state and issues the next write from the done cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    issue      = 1'b0;
    issue_rs   = 1'b0;
    issue_data = 8'h00;
    addr_go    = 1'b0;
    case (state)
      S_PWR_WAIT: begin
        if (cnt == CNT_W'(POWERUP_CYCLES)) begin
          issue      = 1'b1;
          issue_data = init_cmd(4'd0);
          idx_next   = 4'd1;
          state_next = S_INIT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_INIT: begin
        if (done) begin
          if (idx < N_INIT) begin
            issue      = 1'b1;
            issue_data = init_cmd(idx);
            idx_next   = idx + 4'd1;
          end else if (CLEAR_WAIT == 0) begin
            addr_go = 1'b1;
          end else begin
            cnt_next   = CNT_W'(1);
            state_next = S_CLR_WAIT;
          end
        end
      end
      S_CLR_WAIT: begin
        if (cnt == CNT_W'(CLEAR_WAIT)) addr_go = 1'b1;
        else cnt_next = cnt + 1'b1;
      end
      S_ADDR, S_CHAR: begin
        if (done) begin
          if (idx < N_CHARS) begin
            issue      = 1'b1;
            issue_rs   = 1'b1;
            issue_data = frame_char(snap, idx);
            idx_next   = idx + 4'd1;
            state_next = S_CHAR;
          end else if (REFRESH_GAP == 0) begin
            addr_go = 1'b1;
          end else begin
            cnt_next   = CNT_W'(1);
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(REFRESH_GAP)) addr_go = 1'b1;
        else cnt_next = cnt + 1'b1;
      end
      default: state_next = S_PWR_WAIT;
    endcase
    if (addr_go) begin
      issue      = 1'b1;
      issue_rs   = 1'b0;
      issue_data = LCD_DDRAM | {1'b0, DDRAM_ADDR};
      idx_next   = 4'd0;
      state_next = S_ADDR;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_PWR_WAIT;
      cnt   <= '0;
      idx   <= 4'd0;
      snap  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      if (addr_go) begin
        snap  <= '{hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1};
        ready <= 1'b1;
      end
    end
  end

  lcd_strobe u_strobe (
    .clk      (clk),
    .nreset   (nreset),
    .start    (issue),
    .cmd_rs   (issue_rs),
    .cmd_data (issue_data),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .done     (done)
  );

  assign lcd_rw = 1'b0;

endmodule
